// File: rtl/operand_slice_streamer.sv
// rtl/operand_slice_streamer.sv - splits an operand into 2/3-bit slices streamed under valid/ready
//
// Purpose: accepts one unsigned operand of programmable width n (2..MAX_W),
// cuts it LSB-first into 2-bit and 3-bit slices according to in_mode
// (0 = few-3, 1 = max-3), streams one slice per cycle with its bit offset and
// width flag, and collects the whole decomposition into packed pk_* registers.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake (in_ready high exactly in IDLE)
//   in_data/in_nbits      operand and its width n
//   in_mode               0 = few-3, 1 = max-3
//   out_valid/out_ready   slice handshake
//   out_slice/out_w3      slice value (zero-extended when 2 bits) and width flag
//   out_shift/out_last    LSB offset of the slice, final-slice marker
//   done/err              completion pulse, illegal-width pulse
//   pk_slices/pk_shift    packed slice values / offsets, entry i at index i
//   pk_map/pk_count       packed width flags, number of slices
`timescale 1ns/1ps
module operand_slice_streamer #(
    parameter int MAX_W = 16,
    localparam int MAX_S = MAX_W / 2,
    localparam int SW    = $clog2(MAX_W),
    localparam int NW    = $clog2(MAX_W + 1),
    localparam int CW    = $clog2(MAX_S + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAX_W-1:0]   in_data,
    input  logic [NW-1:0]      in_nbits,
    input  logic               in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         out_slice,
    output logic               out_w3,
    output logic [SW-1:0]      out_shift,
    output logic               out_last,
    output logic               done,
    output logic               err,
    output logic [3*MAX_S-1:0] pk_slices,
    output logic [SW*MAX_S-1:0] pk_shift,
    output logic [MAX_S-1:0]   pk_map,
    output logic [CW-1:0]      pk_count
);

    typedef enum logic [1:0] {IDLE, STREAM, FIN} state_t;

    state_t               state_q;
    logic [MAX_W-1:0]     data_q;
    logic [NW-1:0]        n_q;
    logic                 mode_q;
    logic [CW-1:0]        idx_q;
    logic                 out_valid_q, out_w3_q, out_last_q, done_q, err_q;
    logic [2:0]           out_slice_q;
    logic [SW-1:0]        out_shift_q;
    logic [3*MAX_S-1:0]   pk_slices_q;
    logic [SW*MAX_S-1:0]  pk_shift_q;
    logic [MAX_S-1:0]     pk_map_q;
    logic [CW-1:0]        pk_count_q;

    logic                 is_idle, legal;
    logic [MAX_W-1:0]     masked, src_data;
    logic [NW-1:0]        src_n, shift_d, rem;
    logic                 src_mode, w3_d, last_d;
    logic [MAX_W+1:0]     pad;
    logic [2:0]           win, slice_d;

    // The same slice generator serves both the first slice (fed straight from
    // the input port while IDLE) and every following slice (fed from the
    // latched operand), so accept and advance share one datapath.
    always_comb begin
        masked = '0;
        for (int i = 0; i < MAX_W; i++) begin
            masked[i] = in_data[i] & (NW'(i) < in_nbits);
        end
        legal    = (in_nbits >= NW'(2)) && (in_nbits <= NW'(MAX_W));
        is_idle  = (state_q == IDLE);
        src_data = is_idle ? masked   : data_q;
        src_n    = is_idle ? in_nbits : n_q;
        src_mode = is_idle ? in_mode  : mode_q;
        shift_d  = is_idle ? '0 : NW'(out_shift_q) + (out_w3_q ? NW'(3) : NW'(2));
        rem      = src_n - shift_d;
        // max-3 takes a 3-bit slice unless exactly 2 or 4 bits remain, which
        // must end as one or two 2-bit slices; few-3 takes 3 bits only while
        // the remainder is odd, which can only be the first slice.
        w3_d     = src_mode ? ((rem == NW'(3)) || (rem >= NW'(5))) : rem[0];
        last_d   = (rem == (w3_d ? NW'(3) : NW'(2)));
        pad      = {2'b00, src_data};
        win      = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (shift_d == NW'(i)) win = pad[i +: 3];
        end
        slice_d  = w3_d ? win : {1'b0, win[1:0]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            data_q      <= '0;
            n_q         <= '0;
            mode_q      <= 1'b0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_slice_q <= '0;
            out_w3_q    <= 1'b0;
            out_shift_q <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            pk_slices_q <= '0;
            pk_shift_q  <= '0;
            pk_map_q    <= '0;
            pk_count_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q <= masked;
                        n_q    <= in_nbits;
                        mode_q <= in_mode;
                        if (legal) begin
                            state_q     <= STREAM;
                            idx_q       <= '0;
                            out_valid_q <= 1'b1;
                            out_slice_q <= slice_d;
                            out_w3_q    <= w3_d;
                            out_shift_q <= shift_d[SW-1:0];
                            out_last_q  <= last_d;
                            pk_slices_q <= '0;
                            pk_shift_q  <= '0;
                            pk_map_q    <= '0;
                        end else begin
                            // Rejected operand: slice fields keep the previous result.
                            state_q    <= FIN;
                            done_q     <= 1'b1;
                            err_q      <= 1'b1;
                            pk_count_q <= '0;
                        end
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        for (int i = 0; i < MAX_S; i++) begin
                            if (idx_q == CW'(i)) begin
                                pk_slices_q[3*i +: 3]   <= out_slice_q;
                                pk_shift_q[SW*i +: SW]  <= out_shift_q;
                                pk_map_q[i]             <= out_w3_q;
                            end
                        end
                        if (out_last_q) begin
                            state_q     <= FIN;
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            pk_count_q  <= idx_q + CW'(1);
                        end else begin
                            idx_q       <= idx_q + CW'(1);
                            out_slice_q <= slice_d;
                            out_w3_q    <= w3_d;
                            out_shift_q <= shift_d[SW-1:0];
                            out_last_q  <= last_d;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gated by reset so the block never advertises readiness while held in reset.
    assign in_ready  = reset && (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_slice = out_slice_q;
    assign out_w3    = out_w3_q;
    assign out_shift = out_shift_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign err       = err_q;
    assign pk_slices = pk_slices_q;
    assign pk_shift  = pk_shift_q;
    assign pk_map    = pk_map_q;
    assign pk_count  = pk_count_q;

endmodule

// File: tb/tb_operand_slice_streamer.sv
// tb/tb_operand_slice_streamer.sv - self-checking bench for operand_slice_streamer
`timescale 1ns/1ps
module tb_operand_slice_streamer;

    localparam int MAX_W = 16;
    localparam int MAX_S = 8;
    localparam int SW    = 4;
    localparam int NW    = 5;
    localparam int CW    = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [MAX_W-1:0]   in_data = '0;
    logic [NW-1:0]      in_nbits = '0;
    logic               in_mode = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [2:0]         out_slice;
    logic               out_w3;
    logic [SW-1:0]      out_shift;
    logic               out_last;
    logic               done;
    logic               err;
    logic [3*MAX_S-1:0] pk_slices;
    logic [SW*MAX_S-1:0] pk_shift;
    logic [MAX_S-1:0]   pk_map;
    logic [CW-1:0]      pk_count;

    operand_slice_streamer #(.MAX_W(MAX_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_nbits(in_nbits), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_slice(out_slice),
        .out_w3(out_w3), .out_shift(out_shift), .out_last(out_last),
        .done(done), .err(err),
        .pk_slices(pk_slices), .pk_shift(pk_shift), .pk_map(pk_map), .pk_count(pk_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int slice;
        int shift;
        int w3;
        int last;
    } sl_t;

    sl_t                expq[$];
    logic [3*MAX_S-1:0] exp_pk_slices = '0;
    logic [SW*MAX_S-1:0] exp_pk_shift = '0;
    logic [MAX_S-1:0]   exp_pk_map = '0;
    int                 exp_count = 0;
    int                 exp_err = 0;
    int                 nchecks = 0;
    int                 nerrors = 0;
    logic               chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        nchecks++;
        if (act !== expv) begin
            nerrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Model: derive the width list from slice counts, then cut the masked operand.
    task automatic build(input int n, input int mode, input int data, output int s_cnt);
        int widths[$];
        int d, off, w, val, k2, k3;
        s_cnt = 0;
        if (n < 2 || n > MAX_W) begin
            exp_err   = 1;
            exp_count = 0;
            return;
        end
        d = data & ((1 << n) - 1);
        if (mode == 0) begin
            if (n % 2 == 1) widths.push_back(3);
            repeat ((n - (n % 2) * 3) / 2) widths.push_back(2);
        end else begin
            k2 = (n % 3 == 0) ? 0 : ((n % 3 == 2) ? 1 : 2);
            k3 = (n - 2 * k2) / 3;
            repeat (k3) widths.push_back(3);
            repeat (k2) widths.push_back(2);
        end
        exp_pk_slices = '0;
        exp_pk_shift  = '0;
        exp_pk_map    = '0;
        off = 0;
        foreach (widths[i]) begin
            w   = widths[i];
            val = (d >> off) & ((1 << w) - 1);
            expq.push_back('{val, off, (w == 3) ? 1 : 0, (i == widths.size() - 1) ? 1 : 0});
            exp_pk_slices = exp_pk_slices | (24'(val) << (3 * i));
            exp_pk_shift  = exp_pk_shift | (32'(off) << (SW * i));
            exp_pk_map[i] = (w == 3);
            off += w;
        end
        s_cnt     = widths.size();
        exp_count = s_cnt;
        exp_err   = 0;
    endtask

    always @(negedge clk) begin
        if (chk_en && reset) begin
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk("spurious_out_valid", out_valid, 1'b0);
                end else begin
                    chk("out_slice", out_slice, expq[0].slice);
                    chk("out_shift", out_shift, expq[0].shift);
                    chk("out_w3", out_w3, expq[0].w3);
                    chk("out_last", out_last, expq[0].last);
                    if (out_ready) void'(expq.pop_front());
                end
            end
            if (done) begin
                chk("pk_count", pk_count, exp_count);
                chk("err_at_done", err, exp_err);
                chk("pk_slices", pk_slices, exp_pk_slices);
                chk("pk_shift", pk_shift, exp_pk_shift);
                chk("pk_map", pk_map, exp_pk_map);
                chk("slices_left", expq.size(), 0);
            end
        end
    end

    // Runs one operand; entered and left at 1 time unit after a rising edge.
    task automatic op(input int n, input int mode, input int data,
                      input int stall_idx, input int stall_n, input bit poke);
        int s_cnt, dc, wcnt;
        build(n, mode, data, s_cnt);
        wcnt = 0;
        while (!in_ready && wcnt < 20) begin
            @(posedge clk); #1;
            wcnt++;
        end
        if (!in_ready) chk("in_ready_timeout", in_ready, 1'b1);
        in_valid  = 1'b1;
        in_data   = 16'(data);
        in_nbits  = 5'(n);
        in_mode   = mode[0];
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_nbits = 5'($urandom_range(0, 31));
        in_mode  = 1'($urandom_range(0, 1));
        dc = s_cnt + stall_n + 1;
        for (int c = 1; c <= dc + 1; c++) begin
            out_ready = !(c > stall_idx && c <= stall_idx + stall_n);
            in_valid  = poke && (c < dc);
            @(negedge clk);
            chk("done_timing", done, c == dc);
            if (c != dc) chk("err_quiet", err, 1'b0);
            chk("in_ready_timing", in_ready, c == dc + 1);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_slice"}, out_slice, 0);
        chk({tag, "_out_shift"}, out_shift, 0);
        chk({tag, "_out_w3"}, out_w3, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_pk_slices"}, pk_slices, 0);
        chk({tag, "_pk_shift"}, pk_shift, 0);
        chk({tag, "_pk_map"}, pk_map, 0);
        chk({tag, "_pk_count"}, pk_count, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
    endtask

    initial begin
        #3;
        chk_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("in_ready_after_reset", in_ready, 1'b1);
        chk_en = 1'b1;

        op(7, 0, 'h5B, 0, 0, 0);
        chk("lit_n7_slices", pk_slices, 24'h00009B);
        chk("lit_n7_map", pk_map, 8'h01);
        chk("lit_n7_count", pk_count, 3);

        op(8, 1, 'hA7, 0, 0, 0);
        chk("lit_n8_slices", pk_slices, 24'h0000A7);
        chk("lit_n8_map", pk_map, 8'h03);

        op(10, 1, 'h2C5, 0, 0, 0);
        chk("lit_n10_shift", pk_shift, 32'h00008630);
        chk("lit_n10_map", pk_map, 8'h03);
        chk("lit_n10_count", pk_count, 4);

        op(5, 0, 'hFFFF, 0, 0, 0);
        chk("lit_n5_slices", pk_slices, 24'h00001F);
        chk("lit_n5_count", pk_count, 2);

        op(7, 0, 'h5B, 1, 3, 1);
        chk("lit_bp_slices", pk_slices, 24'h00009B);

        op(1, 0, 'h1, 0, 0, 0);
        chk("lit_n1_count", pk_count, 0);
        chk("lit_n1_slices_kept", pk_slices, 24'h00009B);
        op(17, 1, 'h1FFFF, 0, 0, 0);
        chk("lit_n17_count", pk_count, 0);

        op(2, 1, 'hE, 0, 0, 0);
        op(3, 1, 'h5, 0, 0, 0);
        op(4, 1, 'h9, 0, 0, 0);
        op(16, 1, 'hBEEF, 0, 0, 1);
        op(16, 0, 'h1234, 2, 2, 0);
        op(11, 0, 'h7FF, 0, 0, 0);

        chk_en   = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h03FF;
        in_nbits = 5'd10;
        in_mode  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(posedge clk); #1;
        reset = 1'b1;
        expq.delete();
        exp_pk_slices = '0;
        exp_pk_shift  = '0;
        exp_pk_map    = '0;
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_reset_done", done, 1'b0);
            chk("post_reset_valid", out_valid, 1'b0);
            chk("post_reset_ready", in_ready, 1'b1);
            @(posedge clk); #1;
        end

        op(6, 0, 'h39, 0, 0, 0);
        chk("lit_n6_slices", pk_slices, 24'h0000D1);
        chk("lit_n6_map", pk_map, 8'h00);
        chk("lit_n6_count", pk_count, 3);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
